// File: rtl/huffman_param_if.sv
// rtl/huffman_param_if.sv - symbol stream and result bus of the Huffman coder
interface huffman_param_if #(
    parameter int N      = 6,
    parameter int SYM_W  = 8,
    parameter int CNT_W  = 8,
    parameter int CODE_W = 8
);
    logic                gray_valid;
    logic [SYM_W-1:0]    gray_data;
    logic                CNT_valid;
    logic [N*CNT_W-1:0]  CNT;
    logic                code_valid;
    logic [N*CODE_W-1:0] HC;
    logic [N*CODE_W-1:0] M;
    logic                sym_err;

    modport master (
        output gray_valid, gray_data,
        input  CNT_valid, CNT, code_valid, HC, M, sym_err
    );

    modport slave (
        input  gray_valid, gray_data,
        output CNT_valid, CNT, code_valid, HC, M, sym_err
    );
endinterface

// File: rtl/huffman_param.sv
// rtl/huffman_param.sv - burst symbol counter and one-merge-per-cycle Huffman code builder
module huffman_param #(
    parameter int N      = 6,
    parameter int SYM_W  = 8,
    parameter int CNT_W  = 8,
    parameter int CODE_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    huffman_param_if.slave  bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int W_W   = CNT_W + 4;
    localparam int LEN_W = $clog2(CODE_W + 1);

    generate
        if (N < 2 || N > 16) begin : g_bad_n
            $error("huffman_param: N must be in 2..16");
        end
        if (CODE_W < N - 1) begin : g_bad_code_w
            $error("huffman_param: CODE_W must be >= N-1");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, COUNT, CNT_OUT, MERGE, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt    [N];
    logic [CODE_W-1:0] hc     [N];
    logic [CODE_W-1:0] m      [N];
    logic [LEN_W-1:0]  len    [N];
    logic [W_W-1:0]    weight [N];
    logic [N-1:0]      mem    [N];
    logic [N-1:0]      active;
    logic [4:0]        merge_cnt;
    logic              cnt_valid_r, code_valid_r, sym_err_r;

    logic              in_range;
    logic [IDX_W-1:0]  a_idx, b_idx;
    logic              a_found, b_found;

    assign in_range = (bus.gray_data != '0) && (bus.gray_data <= SYM_W'(N));

    // Strict less-than keeps the lowest position on equal weights.
    always_comb begin
        a_idx   = '0;
        b_idx   = '0;
        a_found = 1'b0;
        b_found = 1'b0;
        for (int p = 0; p < N; p++) begin
            if (active[p] && (!a_found || weight[p] < weight[a_idx])) begin
                a_idx   = IDX_W'(p);
                a_found = 1'b1;
            end
        end
        for (int p = 0; p < N; p++) begin
            if (active[p] && (IDX_W'(p) != a_idx) && (!b_found || weight[p] < weight[b_idx])) begin
                b_idx   = IDX_W'(p);
                b_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt_valid_r  <= 1'b0;
            code_valid_r <= 1'b0;
            sym_err_r    <= 1'b0;
            merge_cnt    <= '0;
            active       <= '0;
            for (int p = 0; p < N; p++) begin
                cnt[p]    <= '0;
                hc[p]     <= '0;
                m[p]      <= '0;
                len[p]    <= '0;
                weight[p] <= '0;
                mem[p]    <= '0;
            end
        end else begin
            cnt_valid_r  <= 1'b0;
            code_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.gray_valid) begin
                        for (int k = 0; k < N; k++) begin
                            cnt[k] <= (in_range && bus.gray_data == SYM_W'(k + 1)) ? CNT_W'(1) : '0;
                            hc[k]  <= '0;
                            m[k]   <= '0;
                        end
                        sym_err_r <= !in_range;
                        state     <= COUNT;
                    end
                end
                COUNT: begin
                    if (bus.gray_valid) begin
                        if (in_range) begin
                            for (int k = 0; k < N; k++) begin
                                if (bus.gray_data == SYM_W'(k + 1) && cnt[k] != '1)
                                    cnt[k] <= cnt[k] + 1'b1;
                            end
                        end else begin
                            sym_err_r <= 1'b1;
                        end
                    end else begin
                        state       <= CNT_OUT;
                        cnt_valid_r <= 1'b1;
                    end
                end
                CNT_OUT: begin
                    for (int p = 0; p < N; p++) begin
                        weight[p] <= W_W'(cnt[p]);
                        mem[p]    <= N'(1) << p;
                        len[p]    <= '0;
                    end
                    active    <= '1;
                    merge_cnt <= '0;
                    state     <= MERGE;
                end
                MERGE: begin
                    // Each merge prepends one bit: A's members get 1, B's get 0.
                    for (int s = 0; s < N; s++) begin
                        if (mem[a_idx][s] || mem[b_idx][s]) begin
                            hc[s]  <= mem[a_idx][s] ? (hc[s] | (CODE_W'(1) << len[s]))
                                                    : (hc[s] & ~(CODE_W'(1) << len[s]));
                            m[s]   <= m[s] | (CODE_W'(1) << len[s]);
                            len[s] <= len[s] + 1'b1;
                        end
                    end
                    weight[a_idx] <= weight[a_idx] + weight[b_idx];
                    mem[a_idx]    <= mem[a_idx] | mem[b_idx];
                    active[b_idx] <= 1'b0;
                    merge_cnt     <= merge_cnt + 1'b1;
                    if (merge_cnt == 5'(N - 2)) begin
                        state        <= DONE;
                        code_valid_r <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CNT_valid  = cnt_valid_r;
    assign bus.code_valid = code_valid_r;
    assign bus.sym_err    = sym_err_r;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_pack
            assign bus.CNT[g*CNT_W +: CNT_W]  = cnt[g];
            assign bus.HC[g*CODE_W +: CODE_W] = hc[g];
            assign bus.M[g*CODE_W +: CODE_W]  = m[g];
        end
    endgenerate
endmodule

// File: tb/tb_huffman_param.sv
// tb/tb_huffman_param.sv - directed bench for huffman_param with a set-based Huffman model
module tb_huffman_param;
    localparam int N = 6;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       gv    = 1'b0;
    logic [7:0] gd    = 8'd0;

    always #5 clk = ~clk;

    huffman_param_if #(.N(N), .SYM_W(8), .CNT_W(8), .CODE_W(8)) if8 ();
    huffman_param_if #(.N(N), .SYM_W(8), .CNT_W(4), .CODE_W(8)) if4 ();

    assign if8.gray_valid = gv;
    assign if8.gray_data  = gd;
    assign if4.gray_valid = gv;
    assign if4.gray_data  = gd;

    huffman_param #(.N(N), .SYM_W(8), .CNT_W(8), .CODE_W(8)) d8 (.clk(clk), .reset(reset), .bus(if8));
    huffman_param #(.N(N), .SYM_W(8), .CNT_W(4), .CODE_W(8)) d4 (.clk(clk), .reset(reset), .bus(if4));

    int n_chk  = 0;
    int n_fail = 0;

    int e_cnt [2][N];
    int e_hc  [2][N];
    int e_m   [2][N];
    bit e_err;
    int frame_q[$];

    int cyc      = 0;
    int cv_cyc [2];
    int cv_cnt   = 0;
    int done_cnt = 0;
    bit armed    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_syms(input int sym, input int times);
        for (int k = 0; k < times; k++) frame_q.push_back(sym);
    endtask

    // Counts with saturation, then repeated min-pair merging over symbol sets.
    task automatic build_model();
        e_err = 1'b0;
        for (int i = 0; i < 2; i++) begin
            int maxc;
            int wt [N];
            int st [N];
            bit live [N];
            int ln [N];
            maxc = (i == 0) ? 255 : 15;
            for (int s = 0; s < N; s++) begin
                e_cnt[i][s] = 0; e_hc[i][s] = 0; e_m[i][s] = 0;
            end
            foreach (frame_q[k]) begin
                if (frame_q[k] >= 1 && frame_q[k] <= N) begin
                    if (e_cnt[i][frame_q[k]-1] < maxc) e_cnt[i][frame_q[k]-1]++;
                end else begin
                    e_err = 1'b1;
                end
            end
            for (int p = 0; p < N; p++) begin
                wt[p] = e_cnt[i][p]; st[p] = 1 << p; live[p] = 1'b1; ln[p] = 0;
            end
            for (int r = 0; r < N - 1; r++) begin
                int a, b;
                a = -1; b = -1;
                for (int p = 0; p < N; p++)
                    if (live[p] && (a < 0 || wt[p] < wt[a])) a = p;
                for (int p = 0; p < N; p++)
                    if (live[p] && p != a && (b < 0 || wt[p] < wt[b])) b = p;
                for (int s = 0; s < N; s++) begin
                    if (((st[a] >> s) & 1) != 0) begin
                        e_hc[i][s] |= 1 << ln[s];
                        e_m[i][s]  |= 1 << ln[s];
                        ln[s]++;
                    end else if (((st[b] >> s) & 1) != 0) begin
                        e_m[i][s] |= 1 << ln[s];
                        ln[s]++;
                    end
                end
                wt[a] += wt[b];
                st[a] |= st[b];
                live[b] = 1'b0;
            end
        end
    endtask

    task automatic check_inst(input int i, input logic cv, input logic kv, input logic [47:0] cntbus,
                              input logic [47:0] hcbus, input logic [47:0] mbus, input logic err);
        int cw;
        cw = (i == 0) ? 8 : 4;
        if (cv) begin
            chk($sformatf("cnt_valid_expected_%0d", i), {63'd0, armed}, 64'd1);
            for (int k = 0; k < N; k++)
                chk($sformatf("cnt_%0d_sym%0d", i, k + 1),
                    64'((cntbus >> (k * cw)) & 48'((1 << cw) - 1)), 64'(e_cnt[i][k]));
            cv_cyc[i] = cyc;
        end
        if (kv) begin
            chk($sformatf("code_valid_expected_%0d", i), {63'd0, armed}, 64'd1);
            chk($sformatf("latency_%0d", i), 64'(cyc - cv_cyc[i]), 64'(N));
            for (int k = 0; k < N; k++) begin
                chk($sformatf("hc_%0d_sym%0d", i, k + 1), 64'((hcbus >> (k * 8)) & 48'hFF), 64'(e_hc[i][k]));
                chk($sformatf("m_%0d_sym%0d", i, k + 1), 64'((mbus >> (k * 8)) & 48'hFF), 64'(e_m[i][k]));
            end
            chk($sformatf("sym_err_%0d", i), {63'd0, err}, {63'd0, e_err});
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            check_inst(0, if8.CNT_valid, if8.code_valid, if8.CNT, if8.HC, if8.M, if8.sym_err);
            check_inst(1, if4.CNT_valid, if4.code_valid, {24'd0, if4.CNT}, if4.HC, if4.M, if4.sym_err);
            if (if8.CNT_valid || if4.CNT_valid) cv_cnt++;
            if (if8.code_valid || if4.code_valid) begin
                done_cnt++;
                armed = 1'b0;
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_flags8"}, {61'd0, if8.CNT_valid, if8.code_valid, if8.sym_err}, 64'd0);
        chk({tag, "_cnt8"}, 64'(if8.CNT), 64'd0);
        chk({tag, "_hc8"}, 64'(if8.HC), 64'd0);
        chk({tag, "_m8"}, 64'(if8.M), 64'd0);
        chk({tag, "_flags4"}, {61'd0, if4.CNT_valid, if4.code_valid, if4.sym_err}, 64'd0);
        chk({tag, "_cnt4"}, 64'(if4.CNT), 64'd0);
        chk({tag, "_hc4"}, 64'(if4.HC), 64'd0);
        chk({tag, "_m4"}, 64'(if4.M), 64'd0);
    endtask

    task automatic send_syms();
        foreach (frame_q[k]) begin
            @(posedge clk); #1;
            gv = 1'b1;
            gd = 8'(frame_q[k]);
        end
        @(posedge clk); #1;
        gv = 1'b0;
        gd = 8'd0;
    endtask

    task automatic run_frame(input string tag);
        int d0;
        d0    = done_cnt;
        armed = 1'b1;
        send_syms();
        for (int k = 0; k < 40 && done_cnt == d0; k++) begin
            @(negedge clk); #1;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic check_hold(input string tag);
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_hold_hc%0d", tag, k + 1), 64'(if8.HC[k*8 +: 8]), 64'(e_hc[0][k]));
            chk($sformatf("%s_hold_cnt%0d", tag, k + 1), 64'(if8.CNT[k*8 +: 8]), 64'(e_cnt[0][k]));
        end
        chk({tag, "_hold_err"}, {63'd0, if8.sym_err}, {63'd0, e_err});
    endtask

    task automatic load_test1();
        frame_q.delete();
        for (int s = 1; s <= N; s++) add_syms(s, s);
        build_model();
    endtask

    task automatic load_test4();
        frame_q.delete();
        add_syms(0, 1); add_syms(3, 1); add_syms(7, 1);
        build_model();
    endtask

    initial begin
        int lit1_hc [N] = '{7, 6, 2, 3, 2, 0};
        int lit1_m  [N] = '{15, 15, 7, 3, 3, 3};
        int lit2_hc [N] = '{3, 2, 1, 0, 3, 2};
        int lit2_m  [N] = '{7, 7, 7, 7, 3, 3};
        int d0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_zero("reset");

        load_test1();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("model_t1_hc%0d", k + 1), 64'(e_hc[0][k]), 64'(lit1_hc[k]));
            chk($sformatf("model_t1_m%0d", k + 1), 64'(e_m[0][k]), 64'(lit1_m[k]));
        end
        run_frame("t1");
        check_hold("t1");

        frame_q.delete();
        for (int r = 0; r < 4; r++)
            for (int s = 1; s <= N; s++) add_syms(s, 1);
        build_model();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("model_t2_hc%0d", k + 1), 64'(e_hc[0][k]), 64'(lit2_hc[k]));
            chk($sformatf("model_t2_m%0d", k + 1), 64'(e_m[0][k]), 64'(lit2_m[k]));
        end
        run_frame("t2");

        frame_q.delete();
        add_syms(1, 20); add_syms(2, 1);
        build_model();
        chk("model_t3_sat_cnt1", 64'(e_cnt[1][0]), 64'd15);
        chk("model_t3_cnt2", 64'(e_cnt[1][1]), 64'd1);
        chk("model_t3_wide_cnt1", 64'(e_cnt[0][0]), 64'd20);
        run_frame("t3");
        check_hold("t3");

        load_test4();
        chk("model_t4_err", {63'd0, e_err}, 64'd1);
        chk("model_t4_cnt3", 64'(e_cnt[0][2]), 64'd1);
        run_frame("t4");
        check_hold("t4");

        load_test1();
        d0    = cv_cnt;
        armed = 1'b1;
        send_syms();
        for (int k = 0; k < 20 && cv_cnt == d0; k++) begin
            @(negedge clk); #1;
        end
        chk("t5_cnt_valid_seen", 64'(cv_cnt - d0), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        armed = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_zero("t5_abort");
        repeat (12) @(negedge clk);
        #1;
        run_frame("t5_after");

        load_test4();
        run_frame("t6_f1");
        load_test1();
        run_frame("t6_f2");
        check_hold("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
